// File: rtl/sram_axi_slave_pkg.sv
// Purpose: shared types and constants for the AXI4-to-single-port-SRAM responder.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package sram_axi_slave_pkg;

  // AXI field widths that do not depend on the block parameters
  localparam int AXI_LEN_W   = 4;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;

  // AXI response codes
  localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;

  // One transaction in flight: idle, streaming read beats, taking write beats, write response
  typedef enum logic [1:0] {
    SRAM_SLV_IDLE   = 2'd0,
    SRAM_SLV_R_DATA = 2'd1,
    SRAM_SLV_W_DATA = 2'd2,
    SRAM_SLV_W_RESP = 2'd3
  } sram_slv_state_t;

endpackage

// File: rtl/sram_axi_slave.sv
// Purpose: AXI4 responder (INCR bursts 1-16 beats, byte strobes) in front of one single-port word SRAM.
// Latency: first R beat 1 cycle after AR accept, then 1 beat/cycle; W beats accepted every cycle; B the cycle after WLAST.
// Backpressure: RREADY low re-reads the same word so RDATA holds; BVALID holds until BREADY; one transaction at a time.
module sram_axi_slave
  import sram_axi_slave_pkg::*;
#(
  parameter int ID_W    = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SRAM_AW = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  // write address
  input  logic [ID_W-1:0]        i_awid,
  input  logic [ADDR_W-1:0]      i_awaddr,
  input  logic [AXI_LEN_W-1:0]   i_awlen,
  input  logic [AXI_SIZE_W-1:0]  i_awsize,
  input  logic [AXI_BURST_W-1:0] i_awburst,
  input  logic                   i_awvalid,
  output logic                   o_awready,
  // write data
  input  logic [DATA_W-1:0]      i_wdata,
  input  logic [DATA_W/8-1:0]    i_wstrb,
  input  logic                   i_wlast,
  input  logic                   i_wvalid,
  output logic                   o_wready,
  // write response
  output logic [ID_W-1:0]        o_bid,
  output logic [AXI_RESP_W-1:0]  o_bresp,
  output logic                   o_bvalid,
  input  logic                   i_bready,
  // read address
  input  logic [ID_W-1:0]        i_arid,
  input  logic [ADDR_W-1:0]      i_araddr,
  input  logic [AXI_LEN_W-1:0]   i_arlen,
  input  logic [AXI_SIZE_W-1:0]  i_arsize,
  input  logic [AXI_BURST_W-1:0] i_arburst,
  input  logic                   i_arvalid,
  output logic                   o_arready,
  // read data
  output logic [ID_W-1:0]        o_rid,
  output logic [DATA_W-1:0]      o_rdata,
  output logic [AXI_RESP_W-1:0]  o_rresp,
  output logic                   o_rlast,
  output logic                   o_rvalid,
  input  logic                   i_rready,
  // SRAM macro
  output logic                   o_sram_ceb,
  output logic [DATA_W/8-1:0]    o_sram_web,
  output logic [SRAM_AW-1:0]     o_sram_a,
  output logic [DATA_W-1:0]      o_sram_di,
  input  logic [DATA_W-1:0]      i_sram_do
);

  sram_slv_state_t          r_state;
  sram_slv_state_t          w_state_nxt;
  logic [ID_W-1:0]          r_id;
  logic [SRAM_AW-1:0]       r_addr;
  logic [AXI_LEN_W-1:0]     r_cnt;
  logic [AXI_LEN_W-1:0]     r_len;
  logic                     r_err;

  logic                     w_aw_hs;
  logic                     w_ar_hs;
  logic                     w_r_hs;
  logic                     w_w_hs;
  logic [SRAM_AW-1:0]       w_aw_idx;
  logic [SRAM_AW-1:0]       w_ar_idx;
  logic                     w_unused;

  // Word index from the byte address; bits above the SRAM range simply wrap
  assign w_aw_idx = i_awaddr[SRAM_AW+1:2];
  assign w_ar_idx = i_araddr[SRAM_AW+1:2];

  // Burst type and size are ignored: every burst is INCR of full words
  assign w_unused = ^{i_awsize, i_awburst, i_arsize, i_arburst,
                      i_awaddr[ADDR_W-1:SRAM_AW+2], i_awaddr[1:0],
                      i_araddr[ADDR_W-1:SRAM_AW+2], i_araddr[1:0]};

  // Next-state decode plus all channel and SRAM outputs for the current state
  always_comb begin
    w_state_nxt = r_state;
    w_aw_hs     = 1'b0;
    w_ar_hs     = 1'b0;
    w_r_hs      = 1'b0;
    w_w_hs      = 1'b0;
    o_awready   = 1'b0;
    o_arready   = 1'b0;
    o_wready    = 1'b0;
    o_bvalid    = 1'b0;
    o_rvalid    = 1'b0;
    o_rlast     = 1'b0;
    o_bid       = r_id;
    o_rid       = r_id;
    o_rdata     = i_sram_do;
    o_rresp     = RESP_OKAY;
    o_bresp     = r_err ? RESP_SLVERR : RESP_OKAY;
    o_sram_ceb  = 1'b1;
    o_sram_web  = '1;
    o_sram_a    = r_addr;
    o_sram_di   = i_wdata;
    case (r_state)
      SRAM_SLV_IDLE: begin
        // write has priority when both address channels are valid
        o_awready = 1'b1;
        o_arready = ~i_awvalid;
        w_aw_hs   = i_awvalid;
        w_ar_hs   = i_arvalid & ~i_awvalid;
        if (w_aw_hs) begin
          w_state_nxt = SRAM_SLV_W_DATA;
        end else if (w_ar_hs) begin
          // launch the first read now so beat 0 is ready next cycle
          o_sram_ceb  = 1'b0;
          o_sram_a    = w_ar_idx;
          w_state_nxt = SRAM_SLV_R_DATA;
        end
      end
      SRAM_SLV_R_DATA: begin
        o_rvalid   = 1'b1;
        o_rlast    = (r_cnt == r_len);
        w_r_hs     = i_rready;
        // re-read the current word under backpressure, prefetch the next on accept
        o_sram_ceb = 1'b0;
        o_sram_a   = i_rready ? r_addr + 1'b1 : r_addr;
        if (i_rready && o_rlast) begin
          w_state_nxt = SRAM_SLV_IDLE;
        end
      end
      SRAM_SLV_W_DATA: begin
        o_wready = 1'b1;
        w_w_hs   = i_wvalid;
        if (i_wvalid) begin
          // an all-zero strobe still consumes the beat but writes nothing
          o_sram_ceb = 1'b0;
          o_sram_web = ~i_wstrb;
          if (i_wlast) begin
            w_state_nxt = SRAM_SLV_W_RESP;
          end
        end
      end
      SRAM_SLV_W_RESP: begin
        o_bvalid = 1'b1;
        if (i_bready) begin
          w_state_nxt = SRAM_SLV_IDLE;
        end
      end
      default: w_state_nxt = SRAM_SLV_IDLE;
    endcase
  end

  // State and transaction context; reset abandons any burst in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SRAM_SLV_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        SRAM_SLV_IDLE: begin
          if (w_aw_hs) begin
            r_id   <= i_awid;
            r_addr <= w_aw_idx;
            r_len  <= i_awlen;
            r_cnt  <= '0;
            r_err  <= 1'b0;
          end else if (w_ar_hs) begin
            r_id   <= i_arid;
            r_addr <= w_ar_idx;
            r_len  <= i_arlen;
            r_cnt  <= '0;
          end
        end
        SRAM_SLV_R_DATA: begin
          if (w_r_hs && !o_rlast) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        SRAM_SLV_W_DATA: begin
          if (w_w_hs) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt + 1'b1;
            // WLAST ends the burst; a beat count that disagrees with AWLEN is flagged
            if (i_wlast) begin
              r_err <= (r_cnt != r_len);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_axi_slave.sv
// Purpose: self-checking bench for sram_axi_slave with a behavioural SRAM and a transaction-level memory model.
// Latency: checks first R beat one cycle after AR accept and B after the last W beat.
// Backpressure: randomly stalls RREADY, BREADY and WVALID.
module tb_sram_axi_slave;

  localparam int ID_W    = 8;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int SRAM_AW = 14;
  localparam int DEPTH   = 1 << SRAM_AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [ID_W-1:0]   awid, arid, bid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [3:0]        awlen, arlen;
  logic [2:0]        awsize, arsize;
  logic [1:0]        awburst, arburst, bresp, rresp;
  logic              awvalid, awready, arvalid, arready;
  logic [DATA_W-1:0] wdata, rdata;
  logic [3:0]        wstrb;
  logic              wlast, wvalid, wready;
  logic              bvalid, bready;
  logic              rlast, rvalid, rready;
  logic              sram_ceb;
  logic [3:0]        sram_web;
  logic [SRAM_AW-1:0] sram_a;
  logic [DATA_W-1:0] sram_di;
  logic [DATA_W-1:0] sram_do;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [0:DEPTH-1];
  logic [31:0] sram    [0:DEPTH-1];
  logic        sram_init_done = 1'b0;
  logic [31:0] wd [0:15];
  logic [3:0]  ws [0:15];

  sram_axi_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRAM_AW(SRAM_AW)) dut (
    .clk(clk), .rst(rst),
    .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen), .i_awsize(awsize), .i_awburst(awburst),
    .i_awvalid(awvalid), .o_awready(awready),
    .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(wready),
    .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
    .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen), .i_arsize(arsize), .i_arburst(arburst),
    .i_arvalid(arvalid), .o_arready(arready),
    .o_rid(rid), .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast), .o_rvalid(rvalid), .i_rready(rready),
    .o_sram_ceb(sram_ceb), .o_sram_web(sram_web), .o_sram_a(sram_a), .o_sram_di(sram_di),
    .i_sram_do(sram_do)
  );

  // Initial memory image, shared by the SRAM model and the reference memory
  function automatic logic [31:0] init_word(input int i);
    if (i == 'h10) return 32'hDEADBEEF;
    if (i >= 'h40 && i <= 'h43) return 32'h1111_0000 + 32'(i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (strb[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  // Single-port SRAM macro: registered read, per-byte active-low write enable
  always @(posedge clk) begin
    if (!sram_init_done) begin
      for (int i = 0; i < DEPTH; i++) sram[i] = init_word(i);
      sram_init_done = 1'b1;
    end
    if (!sram_ceb) begin
      if (sram_web == 4'hF) sram_do <= sram[sram_a];
      else for (int k = 0; k < 4; k++) if (!sram_web[k]) sram[sram_a][8*k +: 8] = sram_di[8*k +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic ar_phase(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
    int n = 0;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = 3'($urandom); arburst = 2'($urandom); arvalid = 1'b1;
    #1;
    chk("ar_pre_rvalid", 32'(rvalid), 0);
    while (!arready && n < 100) begin @(negedge clk); #1; n++; end
    chk("ar_ready", 32'(arready), 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("r_first_valid", 32'(rvalid), 1);
  endtask

  // stall_beat: >=0 stall that beat stall_n cycles, -1 random stalls, -2 none
  task automatic r_phase(input logic [7:0] id, input int idx, input int len, input int nbeats,
                         input int stall_beat, input int stall_n);
    logic [31:0] exp;
    int st;
    for (int b = 0; b < nbeats; b++) begin
      exp = ref_mem[(idx + b) % DEPTH];
      if (stall_beat == -1) st = $urandom_range(0, 2);
      else if (stall_beat == b) st = stall_n;
      else st = 0;
      for (int s = 0; s < st; s++) begin
        @(negedge clk); rready = 1'b0; #1;
        chk("r_hold_valid", 32'(rvalid), 1);
        chk("r_hold_data", rdata, exp);
      end
      @(negedge clk); rready = 1'b1; #1;
      chk("r_valid", 32'(rvalid), 1);
      chk("r_data", rdata, exp);
      chk("r_id", 32'(rid), 32'(id));
      chk("r_last", 32'(rlast), 32'(b == len));
      chk("r_resp", 32'(rresp), 0);
      @(posedge clk); #1;
      rready = 1'b0;
    end
  endtask

  task automatic aw_phase(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
    int n = 0;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = 3'($urandom); awburst = 2'($urandom); awvalid = 1'b1;
    #1;
    while (!awready && n < 100) begin @(negedge clk); #1; n++; end
    chk("aw_ready", 32'(awready), 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("w_ready_after_aw", 32'(wready), 1);
  endtask

  task automatic w_phase(input int idx, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      if ($urandom_range(0, 3) == 0) begin @(negedge clk); wvalid = 1'b0; end
      @(negedge clk);
      wdata = wd[b]; wstrb = ws[b]; wlast = (b == nbeats - 1); wvalid = 1'b1;
      #1;
      chk("w_ready", 32'(wready), 1);
      @(posedge clk); #1;
      wvalid = 1'b0; wlast = 1'b0;
      ref_mem[(idx + b) % DEPTH] = merge(ref_mem[(idx + b) % DEPTH], wd[b], ws[b]);
    end
  endtask

  task automatic b_phase(input logic [7:0] id, input logic [1:0] resp, input int dly);
    int n = 0;
    @(negedge clk); #1;
    while (!bvalid && n < 100) begin @(negedge clk); #1; n++; end
    chk("b_valid", 32'(bvalid), 1);
    for (int d = 0; d < dly; d++) begin
      chk("b_hold_id", 32'(bid), 32'(id));
      @(negedge clk); #1;
    end
    chk("b_id", 32'(bid), 32'(id));
    chk("b_resp", 32'(bresp), 32'(resp));
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk); #1;
    chk("b_done", 32'(bvalid), 0);
    chk("idle_awready", 32'(awready), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] o81, o82, o83, a;
    int len, nb, idx;
    logic [7:0] id;
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

    // reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_awready", 32'(awready), 1);
    chk("rst_arready", 32'(arready), 1);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rlast", 32'(rlast), 0);
    chk("rst_bresp", 32'(bresp), 0);
    chk("rst_rresp", 32'(rresp), 0);
    chk("rst_ceb", 32'(sram_ceb), 1);
    chk("rst_web", 32'(sram_web), 32'hF);
    awvalid = 1'b1; #1;
    chk("rst_arready_awv", 32'(arready), 0);
    awvalid = 1'b0; #1;
    @(negedge clk); rst = 1'b0;

    // single read
    ar_phase(8'h21, 32'h40, 4'd0);
    r_phase(8'h21, 'h10, 0, 1, -2, 0);

    // 4-beat read with beat 2 held off for 3 cycles
    ar_phase(8'h05, 32'h100, 4'd3);
    r_phase(8'h05, 'h40, 3, 4, 1, 3);

    // strobed write burst
    o81 = ref_mem['h81]; o82 = ref_mem['h82]; o83 = ref_mem['h83];
    for (int b = 0; b < 4; b++) wd[b] = 32'hAABBCCDD ^ {4{8'(b)}};
    ws[0] = 4'hF; ws[1] = 4'h3; ws[2] = 4'hC; ws[3] = 4'h0;
    aw_phase(8'h3C, 32'h200, 4'd3);
    w_phase('h80, 4);
    b_phase(8'h3C, 2'b00, 1);
    chk("wr_w80", sram['h80], 32'hAABBCCDD);
    chk("wr_w81", sram['h81], {o81[31:16], 16'hCDDC});
    chk("wr_w82", sram['h82], {16'hA8B9, o82[15:0]});
    chk("wr_w83", sram['h83], o83);

    // simultaneous AW and AR: write wins, read returns the new data afterwards
    for (int b = 0; b < 2; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
    @(negedge clk);
    awid = 8'h61; awaddr = 32'h300; awlen = 4'd1; awvalid = 1'b1;
    arid = 8'h62; araddr = 32'h300; arlen = 4'd1; arvalid = 1'b1;
    #1;
    chk("both_awready", 32'(awready), 1);
    chk("both_arready", 32'(arready), 0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("ar_blocked", 32'(arready), 0);
    w_phase('hC0, 2);
    b_phase(8'h61, 2'b00, 0);
    chk("ar_after_b", 32'(arready), 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("r_first_after_b", 32'(rvalid), 1);
    r_phase(8'h62, 'hC0, 1, 2, -2, 0);

    // early WLAST -> SLVERR
    for (int b = 0; b < 2; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
    aw_phase(8'h7E, 32'h400, 4'd3);
    w_phase('h100, 2);
    b_phase(8'h7E, 2'b10, 2);

    // read wrapping past the top of the SRAM index
    ar_phase(8'h77, 32'h0000FFF8, 4'd3);
    r_phase(8'h77, 'h3FFE, 3, 4, -1, 0);

    // reset during beat 3 of an 8-beat read
    ar_phase(8'h44, 32'h500, 4'd7);
    r_phase(8'h44, 'h140, 7, 2, -2, 0);
    @(negedge clk); #1;
    chk("pre_rst_rvalid", 32'(rvalid), 1);
    rst = 1'b1; #1;
    chk("mid_rst_rvalid", 32'(rvalid), 0);
    chk("mid_rst_awready", 32'(awready), 1);
    chk("mid_rst_bvalid", 32'(bvalid), 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post_rst_rvalid", 32'(rvalid), 0);
    ar_phase(8'h45, 32'h600, 4'd2);
    r_phase(8'h45, 'h180, 2, 3, -1, 0);

    // randomized mix of reads and writes
    for (int t = 0; t < 40; t++) begin
      id  = 8'($urandom);
      a   = $urandom;
      idx = int'(a[15:2]);
      len = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 0) begin
        ar_phase(id, a, 4'(len));
        r_phase(id, idx, len, len + 1, -1, 0);
      end else begin
        nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 16) : len + 1;
        for (int b = 0; b < nb; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
        aw_phase(id, a, 4'(len));
        w_phase(idx, nb);
        b_phase(id, ((nb - 1) != len) ? 2'b10 : 2'b00, $urandom_range(0, 2));
      end
    end

    // whole-memory comparison against the reference
    begin
      int nmis = 0;
      for (int i = 0; i < DEPTH; i++) if (sram[i] !== ref_mem[i]) nmis++;
      chk("mem_final", 32'(nmis), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
